// File: rtl/toggle_pulse_debouncer_pkg.sv
// Shared constants for the toggle pulse debouncer: FSM state encoding and
// default timing parameters.
package toggle_pkg;

  // Debounce FSM states: stable-low, arming-high, stable-high, arming-low.
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ARM_HIGH = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;
  localparam logic [1:0] ARM_LOW  = 2'd3;

  localparam int SYNC_STAGES_DEFAULT     = 2;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/toggle_pulse_debouncer_bit_sync.sv
// Multi-flop synchroniser bringing an asynchronous single-bit input into the
// clk domain. Every stage clears to 0 on reset.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Shift the raw input through the flop chain; oldest sample at the top bit.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every stage take its neighbour's old
    // value, so the chain really is STAGES flops deep rather than one.
    if (rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/toggle_pulse_debouncer.sv
// Push-button front end for a T flip-flop: synchronises a bouncy button,
// debounces it with a 4-state FSM, and emits one single-cycle t_out pulse per
// accepted press. Also exports the debounced level and a wrapping press count.
module toggle_pulse_debouncer
  import toggle_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int PCNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_in,
  input  logic              en,
  output logic              t_out,
  output logic              btn_level,
  output logic [PCNT_W-1:0] press_cnt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);

  logic              w_sync_btn;
  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_accept;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_t_out;
  logic              r_btn_level;
  logic [PCNT_W-1:0] r_press_cnt;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_bit_sync (
    .clk (clk),
    .rst (rst),
    .i_d (btn_in),
    .o_q (w_sync_btn)
  );

  // Next-state and debounce-count logic; w_accept flags the press-accept edge.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves a
    // signal unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sync_btn) begin
          w_state_nxt = ARM_HIGH;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      ARM_HIGH: begin
        if (!w_sync_btn) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = HELD;
          w_accept    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!w_sync_btn) begin
          w_state_nxt = ARM_LOW;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      ARM_LOW: begin
        if (w_sync_btn) begin
          w_state_nxt = HELD;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM state and debounce counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Output registers: toggle pulse gated by en, debounced level, press count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_t_out     <= 1'b0;
      r_btn_level <= 1'b0;
      r_press_cnt <= '0;
    end else begin
      r_t_out     <= w_accept & en;
      r_btn_level <= (w_state_nxt == HELD) || (w_state_nxt == ARM_LOW);
      if (w_accept) begin
        r_press_cnt <= r_press_cnt + PCNT_ONE;
      end
    end
  end

  assign t_out     = r_t_out;
  assign btn_level = r_btn_level;
  assign press_cnt = r_press_cnt;

endmodule
